// File: rtl/multi_serial_out.sv
// multi_serial_out: NUM_CH independent serial shifters, each bit lasting one of
// two programmable periods, synchronised at a pass barrier that supports counted
// or infinite repeats. Sits between the control registers and the output pins.
module multi_serial_out #(
    parameter int DATA_BIT = 32,
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 8,
    parameter int RPT_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    input  logic                       i_stop,
    input  logic [NUM_CH-1:0]          i_ch_en,
    input  logic [NUM_CH-1:0]          i_idle_level,
    input  logic [RPT_W-1:0]           i_repeat,
    input  logic [CNT_W-1:0]           i_high_period,
    input  logic [CNT_W-1:0]           i_low_period,
    input  logic [NUM_CH*DATA_BIT-1:0] i_output_pattern,
    input  logic [NUM_CH*DATA_BIT-1:0] i_freq_pattern,
    output logic [NUM_CH-1:0]          o_serial_out,
    output logic [NUM_CH-1:0]          o_bit_tick,
    output logic                       o_pass_tick,
    output logic                       o_done_tick,
    output logic                       o_busy
);

    localparam int                IDX_W    = $clog2(DATA_BIT);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BIT - 1);
    localparam logic [RPT_W-1:0]  RPT_INF  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_BARRIER
    } top_state_e;

    typedef enum logic [1:0] {
        CH_OFF,
        CH_SHIFT,
        CH_WAIT
    } ch_state_e;

    top_state_e          top_q, top_d;
    ch_state_e           ch_state_q [NUM_CH];
    ch_state_e           ch_state_d [NUM_CH];
    logic [CNT_W-1:0]    cnt_q      [NUM_CH];
    logic [CNT_W-1:0]    cnt_d      [NUM_CH];
    logic [IDX_W-1:0]    idx_q      [NUM_CH];
    logic [IDX_W-1:0]    idx_d      [NUM_CH];
    logic [DATA_BIT-1:0] data_q     [NUM_CH];
    logic [DATA_BIT-1:0] data_d     [NUM_CH];
    logic [DATA_BIT-1:0] freq_q     [NUM_CH];
    logic [DATA_BIT-1:0] freq_d     [NUM_CH];

    logic [NUM_CH-1:0]   ch_en_q, ch_en_d;
    logic [NUM_CH-1:0]   idle_q, idle_d;
    logic [NUM_CH-1:0]   out_q, out_d;
    logic [CNT_W-1:0]    high_q, high_d;
    logic [CNT_W-1:0]    low_q, low_d;
    logic [RPT_W-1:0]    rpt_q, rpt_d;
    logic                busy_q, busy_d;
    logic                pass_q, pass_d;
    logic                done_q, done_d;

    logic [CNT_W-1:0]    period_sel  [NUM_CH];
    logic [CNT_W-1:0]    period_last [NUM_CH];
    logic [NUM_CH-1:0]   bit_end;
    logic                pass_end;
    logic                load_pass;
    logic [NUM_CH-1:0]   load_en;

    // Per-channel end-of-bit detection and the "every enabled channel finishes" condition.
    always_comb begin
        bit_end  = '0;
        pass_end = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            period_sel[c]  = freq_q[c][idx_q[c]] ? high_q : low_q;
            period_last[c] = (period_sel[c] == '0) ? '0 : (period_sel[c] - CNT_W'(1));
            bit_end[c]     = (ch_state_q[c] == CH_SHIFT) && (cnt_q[c] == period_last[c]);
            if (ch_en_q[c] &&
                !((ch_state_q[c] == CH_WAIT) || (bit_end[c] && (idx_q[c] == LAST_IDX)))) begin
                pass_end = 1'b0;
            end
        end
    end

    // Next-state logic for the top FSM, the channel FSMs and all latched configuration.
    always_comb begin
        top_d     = top_q;
        busy_d    = busy_q;
        pass_d    = 1'b0;
        done_d    = 1'b0;
        out_d     = out_q;
        ch_en_d   = ch_en_q;
        idle_d    = idle_q;
        high_d    = high_q;
        low_d     = low_q;
        rpt_d     = rpt_q;
        load_pass = 1'b0;
        load_en   = ch_en_q;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_state_d[c] = ch_state_q[c];
            cnt_d[c]      = cnt_q[c];
            idx_d[c]      = idx_q[c];
            data_d[c]     = data_q[c];
            freq_d[c]     = freq_q[c];
        end

        case (top_q)
            ST_IDLE: begin
                out_d = i_idle_level;
                if (i_start && (i_ch_en != '0) && !i_stop) begin
                    top_d     = ST_RUN;
                    busy_d    = 1'b1;
                    ch_en_d   = i_ch_en;
                    idle_d    = i_idle_level;
                    rpt_d     = i_repeat;
                    load_pass = 1'b1;
                    load_en   = i_ch_en;
                end
            end

            ST_RUN: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    case (ch_state_q[c])
                        CH_SHIFT: begin
                            if (bit_end[c]) begin
                                cnt_d[c] = '0;
                                if (idx_q[c] == LAST_IDX) begin
                                    ch_state_d[c] = CH_WAIT;
                                end else begin
                                    idx_d[c]    = idx_q[c] + IDX_W'(1);
                                    out_d[c]    = data_q[c][idx_q[c] + IDX_W'(1)];
                                end
                            end else begin
                                cnt_d[c] = cnt_q[c] + CNT_W'(1);
                            end
                        end
                        CH_OFF: begin
                            out_d[c] = idle_q[c];
                        end
                        default: begin
                        end
                    endcase
                end
                if (pass_end) begin
                    top_d = ST_BARRIER;
                end
            end

            ST_BARRIER: begin
                if (rpt_q != '0) begin
                    top_d     = ST_RUN;
                    pass_d    = 1'b1;
                    load_pass = 1'b1;
                    if (rpt_q != RPT_INF) begin
                        rpt_d = rpt_q - RPT_W'(1);
                    end
                end else begin
                    top_d  = ST_IDLE;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    out_d  = idle_q;
                    for (int c = 0; c < NUM_CH; c++) begin
                        ch_state_d[c] = CH_OFF;
                    end
                end
            end

            default: begin
                top_d = ST_IDLE;
            end
        endcase

        if (load_pass) begin
            high_d = i_high_period;
            low_d  = i_low_period;
            for (int c = 0; c < NUM_CH; c++) begin
                data_d[c] = i_output_pattern[c*DATA_BIT +: DATA_BIT];
                freq_d[c] = i_freq_pattern[c*DATA_BIT +: DATA_BIT];
                idx_d[c]  = '0;
                cnt_d[c]  = '0;
                if (load_en[c]) begin
                    ch_state_d[c] = CH_SHIFT;
                    out_d[c]      = i_output_pattern[c*DATA_BIT];
                end else begin
                    ch_state_d[c] = CH_OFF;
                    out_d[c]      = idle_d[c];
                end
            end
        end

        // Abort wins over everything else, including a barrier reload or completion.
        if (i_stop && (top_q != ST_IDLE)) begin
            top_d  = ST_IDLE;
            busy_d = 1'b0;
            pass_d = 1'b0;
            done_d = 1'b0;
            out_d  = idle_q;
            for (int c = 0; c < NUM_CH; c++) begin
                ch_state_d[c] = CH_OFF;
            end
        end
    end

    // State and configuration registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q   <= ST_IDLE;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            ch_en_q <= '0;
            idle_q  <= '0;
            high_q  <= '0;
            low_q   <= '0;
            rpt_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                ch_state_q[c] <= CH_OFF;
                cnt_q[c]      <= '0;
                idx_q[c]      <= '0;
                data_q[c]     <= '0;
                freq_q[c]     <= '0;
            end
        end else begin
            top_q   <= top_d;
            busy_q  <= busy_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            out_q   <= out_d;
            ch_en_q <= ch_en_d;
            idle_q  <= idle_d;
            high_q  <= high_d;
            low_q   <= low_d;
            rpt_q   <= rpt_d;
            for (int c = 0; c < NUM_CH; c++) begin
                ch_state_q[c] <= ch_state_d[c];
                cnt_q[c]      <= cnt_d[c];
                idx_q[c]      <= idx_d[c];
                data_q[c]     <= data_d[c];
                freq_q[c]     <= freq_d[c];
            end
        end
    end

    assign o_serial_out = out_q;
    assign o_bit_tick   = bit_end;
    assign o_pass_tick  = pass_q;
    assign o_done_tick  = done_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_multi_serial_out.sv
// tb_multi_serial_out: drives multi_serial_out with directed and randomised runs
// and compares every cycle against a timeline model built from bit durations.
module tb_multi_serial_out;

    localparam int DATA_BIT = 32;
    localparam int NUM_CH   = 4;
    localparam int CNT_W    = 8;
    localparam int RPT_W    = 8;
    localparam logic [RPT_W-1:0] RPT_INF = '1;

    logic                       clk;
    logic                       rst;
    logic                       i_start;
    logic                       i_stop;
    logic [NUM_CH-1:0]          i_ch_en;
    logic [NUM_CH-1:0]          i_idle_level;
    logic [RPT_W-1:0]           i_repeat;
    logic [CNT_W-1:0]           i_high_period;
    logic [CNT_W-1:0]           i_low_period;
    logic [NUM_CH*DATA_BIT-1:0] i_output_pattern;
    logic [NUM_CH*DATA_BIT-1:0] i_freq_pattern;
    logic [NUM_CH-1:0]          o_serial_out;
    logic [NUM_CH-1:0]          o_bit_tick;
    logic                       o_pass_tick;
    logic                       o_done_tick;
    logic                       o_busy;

    int compared;
    int mismatched;

    // Reference timeline: absolute first/last cycle of every bit of the current pass.
    logic [DATA_BIT-1:0] m_pat  [NUM_CH];
    logic [DATA_BIT-1:0] m_freq [NUM_CH];
    int                  bit_first [NUM_CH][DATA_BIT];
    int                  bit_last  [NUM_CH][DATA_BIT];
    logic [NUM_CH-1:0]   m_en;
    logic [NUM_CH-1:0]   m_idle;
    logic [RPT_W-1:0]    m_rpt;
    int                  m_hi;
    int                  m_lo;
    int                  m_t0;
    int                  m_t_end;
    int                  pass_num;

    int tick_count0;
    int done_cycle;
    int first_pass_tick;
    int pass_count;

    multi_serial_out #(
        .DATA_BIT(DATA_BIT),
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .RPT_W   (RPT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_start         (i_start),
        .i_stop          (i_stop),
        .i_ch_en         (i_ch_en),
        .i_idle_level    (i_idle_level),
        .i_repeat        (i_repeat),
        .i_high_period   (i_high_period),
        .i_low_period    (i_low_period),
        .i_output_pattern(i_output_pattern),
        .i_freq_pattern  (i_freq_pattern),
        .o_serial_out    (o_serial_out),
        .o_bit_tick      (o_bit_tick),
        .o_pass_tick     (o_pass_tick),
        .o_done_tick     (o_done_tick),
        .o_busy          (o_busy)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h (time %0t)", tag, got, exp, $time);
        end
    endtask

    // Captures the configuration the DUT samples at start or at a barrier reload.
    task automatic snapshot_cfg();
        m_hi = int'(i_high_period);
        m_lo = int'(i_low_period);
        for (int c = 0; c < NUM_CH; c++) begin
            m_pat[c]  = i_output_pattern[c*DATA_BIT +: DATA_BIT];
            m_freq[c] = i_freq_pattern[c*DATA_BIT +: DATA_BIT];
        end
    endtask

    // Lays out every bit of a pass whose bit 0 is first visible in cycle t0.
    task automatic compute_pass(input int t0);
        int t;
        int p;
        m_t0    = t0;
        m_t_end = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (m_en[c]) begin
                t = t0;
                for (int k = 0; k < DATA_BIT; k++) begin
                    p = m_freq[c][k] ? m_hi : m_lo;
                    if (p == 0) p = 1;
                    bit_first[c][k] = t;
                    bit_last[c][k]  = t + p - 1;
                    t += p;
                end
                if (t - 1 > m_t_end) m_t_end = t - 1;
            end
        end
    endtask

    // Random disturbance of every input the DUT must ignore mid-pass.
    task automatic applyStimulus();
        if ($urandom_range(0, 3) == 0) begin
            for (int c = 0; c < NUM_CH; c++) begin
                i_output_pattern[c*DATA_BIT +: DATA_BIT] = DATA_BIT'($urandom());
                i_freq_pattern[c*DATA_BIT +: DATA_BIT]   = DATA_BIT'($urandom());
            end
            i_high_period = CNT_W'($urandom_range(0, 3));
            i_low_period  = CNT_W'($urandom_range(0, 3));
            i_repeat      = RPT_W'($urandom_range(0, 3));
            i_ch_en       = NUM_CH'($urandom());
            i_start       = 1'($urandom_range(0, 1));
        end
    endtask

    // Starts a run with the currently driven inputs and checks it cycle by cycle.
    task automatic runScenario(input int stop_at, input int rst_pass, input bit mutate, input int max_cycles);
        int t;
        int phase;
        bit fin;
        logic [NUM_CH-1:0] exp_out;
        logic [NUM_CH-1:0] exp_tick;
        logic exp_busy;
        logic exp_pass;
        logic exp_done;
        int k;

        m_en   = i_ch_en;
        m_idle = i_idle_level;
        m_rpt  = i_repeat;
        snapshot_cfg();
        tick_count0     = 0;
        done_cycle      = -1;
        first_pass_tick = -1;
        pass_count      = 0;
        i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start  = 1'b0;
        t        = 1;
        phase    = 0;
        pass_num = 0;
        fin      = 1'b0;
        compute_pass(1);

        while (!fin) begin
            exp_out  = '0;
            exp_tick = '0;
            if (phase == 0) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (m_en[c]) begin
                        k = 0;
                        for (int b = 0; b < DATA_BIT; b++) begin
                            if (bit_first[c][b] <= t) k = b;
                            if (bit_last[c][b] == t) exp_tick[c] = 1'b1;
                        end
                        exp_out[c] = m_pat[c][k];
                    end else begin
                        exp_out[c] = m_idle[c];
                    end
                end
                exp_busy = 1'b1;
                exp_pass = (t == m_t0) && (pass_num > 0);
                exp_done = 1'b0;
            end else begin
                exp_out  = m_idle;
                exp_busy = 1'b0;
                exp_pass = 1'b0;
                exp_done = (phase == 1);
            end

            if (o_bit_tick[0]) tick_count0++;
            if (o_done_tick && done_cycle < 0) done_cycle = t;
            if (o_pass_tick) begin
                pass_count++;
                if (first_pass_tick < 0) first_pass_tick = t;
            end
            checkOutput("serial_out", 64'(o_serial_out), 64'(exp_out));
            checkOutput("bit_tick", 64'(o_bit_tick), 64'(exp_tick));
            checkOutput("busy", 64'(o_busy), 64'(exp_busy));
            checkOutput("pass_tick", 64'(o_pass_tick), 64'(exp_pass));
            checkOutput("done_tick", 64'(o_done_tick), 64'(exp_done));

            if (phase != 0) begin
                fin = 1'b1;
            end else begin
                if (mutate) applyStimulus();
                if ((rst_pass == pass_num) && (t == m_t0 + 4)) begin
                    rst = 1'b1;
                    #1;
                    checkOutput("rst_serial_out", 64'(o_serial_out), 64'd0);
                    checkOutput("rst_busy", 64'(o_busy), 64'd0);
                    checkOutput("rst_bit_tick", 64'(o_bit_tick), 64'd0);
                    checkOutput("rst_done_tick", 64'(o_done_tick), 64'd0);
                    i_start = 1'b0;
                    @(negedge clk);
                    checkOutput("rst_hold_serial_out", 64'(o_serial_out), 64'd0);
                    rst = 1'b0;
                    fin = 1'b1;
                end else if (t == stop_at) begin
                    i_stop = 1'b1;
                    phase  = 2;
                end else if (t == m_t_end + 1) begin
                    if (m_rpt != '0) begin
                        snapshot_cfg();
                        if (m_rpt != RPT_INF) m_rpt = m_rpt - RPT_W'(1);
                        pass_num++;
                        compute_pass(t + 1);
                    end else begin
                        phase = 1;
                    end
                end
                if (!fin) begin
                    @(negedge clk);
                    t++;
                    if (t > max_cycles) begin
                        checkOutput("cycle_budget", 64'(t), 64'(max_cycles));
                        fin = 1'b1;
                    end
                end
            end
        end
        i_start = 1'b0;
        i_stop  = 1'b0;
        if (rst) begin
            @(negedge clk);
            rst = 1'b0;
        end
        @(negedge clk);
        checkOutput("idle_serial_out", 64'(o_serial_out), 64'(i_idle_level));
        checkOutput("idle_busy", 64'(o_busy), 64'd0);
    endtask

    task automatic set_channel(input int c, input logic [DATA_BIT-1:0] pat, input logic [DATA_BIT-1:0] frq);
        i_output_pattern[c*DATA_BIT +: DATA_BIT] = pat;
        i_freq_pattern[c*DATA_BIT +: DATA_BIT]   = frq;
    endtask

    task automatic randomize_patterns();
        for (int c = 0; c < NUM_CH; c++) begin
            set_channel(c, DATA_BIT'($urandom()), DATA_BIT'($urandom()));
        end
    endtask

    initial begin
        compared         = 0;
        mismatched       = 0;
        rst              = 1'b1;
        i_start          = 1'b0;
        i_stop           = 1'b0;
        i_ch_en          = '0;
        i_idle_level     = '0;
        i_repeat         = '0;
        i_high_period    = '0;
        i_low_period     = '0;
        i_output_pattern = '0;
        i_freq_pattern   = '0;

        // Reset values, then the idle level follows the input in IDLE.
        i_idle_level = 4'b0110;
        repeat (2) @(negedge clk);
        checkOutput("reset_serial_out", 64'(o_serial_out), 64'd0);
        checkOutput("reset_busy", 64'(o_busy), 64'd0);
        checkOutput("reset_ticks", 64'({o_bit_tick, o_pass_tick, o_done_tick}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_follow", 64'(o_serial_out), 64'(4'b0110));

        // Single channel, one fast bit then slow ones: 3 + 31*9 = 282, done at 284.
        $display("[TB] directed: single channel mixed periods");
        i_idle_level  = '0;
        i_ch_en       = 4'b0001;
        i_high_period = 8'd3;
        i_low_period  = 8'd9;
        i_repeat      = '0;
        randomize_patterns();
        set_channel(0, 32'h0000_0005, 32'h0000_0001);
        runScenario(-1, -1, 1'b0, 2000);
        checkOutput("t1_bit_ticks", 64'(tick_count0), 64'd32);
        checkOutput("t1_done_cycle", 64'(done_cycle), 64'd284);

        // Two channels, all-high vs all-low, one repeat: pass 1 ends 288, pass tick 290,
        // pass 2 spans 290..577, barrier 578, done 579.
        $display("[TB] directed: barrier wait and one repeat");
        i_ch_en  = 4'b0011;
        i_repeat = 8'd1;
        randomize_patterns();
        set_channel(0, DATA_BIT'($urandom()), 32'hFFFF_FFFF);
        set_channel(1, DATA_BIT'($urandom()), 32'h0000_0000);
        runScenario(-1, -1, 1'b0, 2000);
        checkOutput("t2_pass_cycle", 64'(first_pass_tick), 64'd290);
        checkOutput("t2_done_cycle", 64'(done_cycle), 64'd579);

        // Zero period behaves as one cycle: every cycle 1..32 is a bit end.
        $display("[TB] directed: minimum periods on all channels");
        i_ch_en       = 4'b1111;
        i_high_period = 8'd0;
        i_low_period  = 8'd1;
        i_repeat      = '0;
        randomize_patterns();
        runScenario(-1, -1, 1'b0, 2000);
        checkOutput("t3_bit_ticks", 64'(tick_count0), 64'd32);
        checkOutput("t3_done_cycle", 64'(done_cycle), 64'd34);

        // Infinite repeat with inputs churning mid-pass, ended by stop.
        $display("[TB] directed: infinite repeat then stop");
        i_high_period = 8'd1;
        i_low_period  = 8'd2;
        i_repeat      = RPT_INF;
        randomize_patterns();
        runScenario(420, -1, 1'b1, 2000);
        checkOutput("t4_passes_ge3", 64'(pass_count >= 3), 64'd1);
        checkOutput("t4_no_done", 64'(done_cycle), 64'hFFFF_FFFF_FFFF_FFFF);

        // Disabled channels keep the latched idle level.
        $display("[TB] directed: idle levels on disabled channels");
        i_idle_level  = 4'b1010;
        i_ch_en       = 4'b0001;
        i_repeat      = '0;
        i_high_period = 8'd2;
        i_low_period  = 8'd1;
        randomize_patterns();
        runScenario(-1, -1, 1'b0, 2000);

        // Start with no channel enabled is ignored.
        i_ch_en = '0;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        checkOutput("noen_busy", 64'(o_busy), 64'd0);
        @(negedge clk);
        checkOutput("noen_busy_later", 64'(o_busy), 64'd0);
        checkOutput("noen_serial_out", 64'(o_serial_out), 64'(4'b1010));

        // Reset during pass 2, then a clean full pass.
        $display("[TB] directed: reset mid pass then restart");
        i_idle_level  = 4'b0101;
        i_ch_en       = 4'b1011;
        i_repeat      = 8'd2;
        i_high_period = 8'd2;
        i_low_period  = 8'd3;
        randomize_patterns();
        runScenario(-1, 1, 1'b0, 2000);
        i_repeat = '0;
        randomize_patterns();
        runScenario(-1, -1, 1'b0, 2000);
        checkOutput("post_rst_done", 64'(done_cycle > 0), 64'd1);

        // Randomised runs: configuration, repeats, stops and mid-run churn.
        for (int n = 0; n < 6; n++) begin
            i_idle_level  = NUM_CH'($urandom());
            i_ch_en       = NUM_CH'($urandom_range(1, 15));
            i_repeat      = RPT_W'($urandom_range(0, 2));
            i_high_period = CNT_W'($urandom_range(0, 3));
            i_low_period  = CNT_W'($urandom_range(0, 3));
            randomize_patterns();
            runScenario(($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 150)) : -1,
                        -1, 1'b1, 2000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
